// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide sequencer beside the execute stage.
// Magnitude shift-add / restoring-divide core; divide-by-zero and overflow resolve in one cycle.
module ex_muldiv #(
  parameter int REG_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [REG_DATA_W-1:0] rs1_data_i,
  input  logic [REG_DATA_W-1:0] rs2_data_i,
  input  logic [4:0]            wreg_addr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wreg_en_o,
  output logic [4:0]            wreg_addr_o,
  output logic [REG_DATA_W-1:0] wreg_data_o
);
  localparam int W  = REG_DATA_W;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [W-1:0]    wdata_q, wdata_d;

  logic            accept, sgn2_en, sgn1_en, s1, s2, div0, ovf, special;
  logic [W-1:0]    mag1, mag2, spec_res, quo, rem, res_fin;
  logic [W:0]      add_sum, sub_shift, sub_diff;
  logic [2*W-1:0]  mul_step, div_step, acc_nx, prod_s;

  assign accept  = (state_q == IDLE) && start_i && !flush_i;

  // Operand sign handling: MULHSU treats only rs1 as signed; *U ops are unsigned.
  assign sgn2_en = (funct3_i[2:1] == 2'b00) || (funct3_i[2] && !funct3_i[0]);
  assign sgn1_en = sgn2_en || (funct3_i == 3'b010);
  assign s1      = sgn1_en && rs1_data_i[W-1];
  assign s2      = sgn2_en && rs2_data_i[W-1];
  assign mag1    = s1 ? -rs1_data_i : rs1_data_i;
  assign mag2    = s2 ? -rs2_data_i : rs2_data_i;

  assign div0    = funct3_i[2] && (rs2_data_i == '0);
  assign ovf     = funct3_i[2] && !funct3_i[0] && (rs1_data_i == {1'b1, {(W-1){1'b0}}})
                   && (rs2_data_i == '1);
  assign special = div0 || ovf;
  assign spec_res = div0 ? (funct3_i[1] ? rs1_data_i : '1)
                         : (funct3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}});

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step  = {add_sum, acc_q[W-1:1]};
  assign sub_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign sub_diff  = sub_shift - {1'b0, b_q};
  assign div_step  = sub_diff[W] ? {sub_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {sub_diff[W-1:0],  acc_q[W-2:0], 1'b1};
  assign acc_nx    = f3_q[2] ? div_step : mul_step;

  assign prod_s = neg_q ? -acc_nx : acc_nx;
  assign quo    = acc_nx[W-1:0];
  assign rem    = acc_nx[2*W-1:W];

  always_comb begin
    res_fin = '0;
    case (f3_q)
      3'b000:                 res_fin = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_s[2*W-1:W];
      3'b100, 3'b101:         res_fin = neg_q ? -quo : quo;
      default:                res_fin = rneg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (accept) begin
        f3_d    = funct3_i;
        b_d     = mag2;
        acc_d   = {{W{1'b0}}, mag1};
        neg_d   = s1 ^ s2;
        rneg_d  = s1;
        waddr_d = wreg_addr_i;
        cnt_d   = '0;
        if (special) begin
          state_d = DONE;
          wdata_d = spec_res;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
          wdata_d = res_fin;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An aborted op must not leave a partial result on the write-back bus.
    if (flush_i) begin
      state_d = IDLE;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign stall_o     = accept || (state_q == CALC);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign wreg_en_o   = done_o;
  assign wreg_addr_o = waddr_q;
  assign wreg_data_o = wdata_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M cases, flush/reset aborts, then random ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  wreg_addr_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o, wreg_en_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.REG_DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wreg_addr_i(wreg_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o), .wreg_data_o(wreg_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    bit          ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op (at posedge+1), hold start through DONE, then verify result and latency.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ad, input string tag);
    logic [31:0] exp_d;
    int          exp_lat, cyc, stl;
    bit          seen;
    exp_d   = ref_res(f3, a, b);
    exp_lat = is_special(f3, a, b) ? 1 : 33;
    start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; wreg_addr_i = ad;
    cyc = 0; stl = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      #2;
      if (done_o) seen = 1'b1;
      else begin
        if (stall_o) stl++;
        cyc++;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_stall_cycles"}, 64'(stl), 64'(exp_lat));
      chk({tag, "_data"}, 64'(wreg_data_o), 64'(exp_d));
      chk({tag, "_addr"}, 64'(wreg_addr_o), 64'(ad));
      chk({tag, "_en_nostall"}, {62'b0, wreg_en_o, stall_o}, 64'b10);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    chk({tag, "_no_reaccept"}, {62'b0, done_o, busy_o}, 64'b0);
  endtask

  task automatic watch_no_done(input int n, input string tag);
    int dn;
    dn = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (done_o || wreg_en_o) dn++;
    end
    chk(tag, 64'(dn), 64'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [31:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h1;

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; wreg_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {57'b0, stall_o, busy_o, done_o, wreg_en_o, 3'b0},  64'b0);
    chk("reset_addr", 64'(wreg_addr_o), 64'd0);
    chk("reset_data", 64'(wreg_data_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, "mulh");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, "remu");
    run_op(3'd5, 32'd5, 32'd0, 5'd9, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 5'd10, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");

    // Flush during CALC cycle 10.
    start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd5; wreg_addr_i = 5'd20;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("flush_idle", {61'b0, busy_o, stall_o, done_o}, 64'b0);
    watch_no_done(40, "flush_no_done");
    run_op(3'd5, 32'd9, 32'd3, 5'd21, "post_flush_divu");

    // Reset during CALC cycle 20.
    start_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; wreg_addr_i = 5'd22;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_flags", {60'b0, stall_o, busy_o, done_o, wreg_en_o}, 64'b0);
    chk("midrst_addr", 64'(wreg_addr_o), 64'd0);
    chk("midrst_data", 64'(wreg_data_o), 64'd0);
    rst_n = 1'b1;
    watch_no_done(40, "midrst_no_done");
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd23, "post_rst_rem");

    // Random ops with occasional corner operands.
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      run_op(rf3, ra, rb, 5'($urandom), $sformatf("rnd%0d_f%0d", n, rf3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
